// File: rtl/cpu_ctrl_seq_if.sv
// rtl/cpu_ctrl_seq_if.sv - instruction-memory and register-file bus of the CPU sequencer
//
// Purpose: bundles the two buses driven by cpu_ctrl_seq.
//   imem_req  : sequencer -> memory, request held until imem_ack
//   imem_addr : sequencer -> memory, fetch address
//   imem_ack  : memory -> sequencer, data valid this cycle
//   imem_data : memory -> sequencer, instruction/operand byte
//   reg_write : sequencer -> register file, one-cycle write strobe
//   reg_read  : sequencer -> register file, read enable
//   reg_addr  : sequencer -> register file, address {4'h0, IR[3:0]}
//   reg_wdata : sequencer -> register file, write data (ACC)
//   reg_rdata : register file -> sequencer, combinational read data
// Modports: master = sequencer side, slave = memory/register-file side.

interface cpu_ctrl_seq_if;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic       reg_write;
  logic       reg_read;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data,
    output reg_write,
    output reg_read,
    output reg_addr,
    output reg_wdata,
    input  reg_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data,
    input  reg_write,
    input  reg_read,
    input  reg_addr,
    input  reg_wdata,
    output reg_rdata
  );
endinterface

// File: rtl/cpu_ctrl_seq.sv
// rtl/cpu_ctrl_seq.sv - fetch/decode/execute sequencer for the 8-bit CPU
//
// Purpose: fetches 8-bit instructions over a req/ack handshake, holds PC, IR,
// ACC and the Z flag, and drives the 16x8 general register file.
// Instruction format: IR[7:4] opcode, IR[3:0] register index.
//
// Ports:
//   clk    : system clock, rising edge
//   rst    : asynchronous active-high reset
//   bus    : cpu_ctrl_seq_if.master (instruction memory + register file)
//   acc    : accumulator
//   zero   : Z flag, set when the last ACC write was 8'h00
//   carry  : C flag (only when CPU_CTRL_CARRY_EN is defined)
//   halted : high in HALT state
//
// Optional feature macro: CPU_CTRL_CARRY_EN adds the C flag, the carry port
// and the ADC (opcode C) / SBC (opcode D) instructions. Without it opcodes
// C and D decode as NOP.
//
// All outputs come from registers updated alongside the state, so no input
// reaches an output combinationally.

module cpu_ctrl_seq #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  cpu_ctrl_seq_if.master   bus,
  output logic [7:0]       acc,
  output logic             zero,
`ifdef CPU_CTRL_CARRY_EN
  output logic             carry,
`endif
  output logic             halted
);

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_NOT = 4'h8;
  localparam logic [3:0] OP_LDI = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_JZ  = 4'hB;
`ifdef CPU_CTRL_CARRY_EN
  localparam logic [3:0] OP_ADC = 4'hC;
  localparam logic [3:0] OP_SBC = 4'hD;
`endif
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_READ,
    ST_WRITE,
    ST_IMM,
    ST_HALT
  } state_t;

  state_t     state_q;
  logic [7:0] pc_q;
  logic [7:0] ir_q;
  logic [7:0] acc_q;
  logic       z_q;
  logic       imem_req_q;
  logic       reg_read_q;
  logic       reg_write_q;
  logic       halted_q;
  logic [3:0] opcode;
  logic [7:0] alu_res;
`ifdef CPU_CTRL_CARRY_EN
  logic       c_q;
  logic       alu_c;
`endif

  assign opcode = ir_q[7:4];

  // ALU result for the READ state; reg_rdata is only meaningful there.
`ifdef CPU_CTRL_CARRY_EN
  // 9-bit arithmetic: bit 8 is carry-out for additions and borrow for
  // subtractions. Non-arithmetic ops leave C untouched.
  always_comb begin
    alu_c   = c_q;
    alu_res = acc_q;
    case (opcode)
      OP_LDA: alu_res = bus.reg_rdata;
      OP_ADD: {alu_c, alu_res} = {1'b0, acc_q} + {1'b0, bus.reg_rdata};
      OP_SUB: {alu_c, alu_res} = {1'b0, acc_q} - {1'b0, bus.reg_rdata};
      OP_AND: alu_res = acc_q & bus.reg_rdata;
      OP_OR:  alu_res = acc_q | bus.reg_rdata;
      OP_XOR: alu_res = acc_q ^ bus.reg_rdata;
      OP_ADC: {alu_c, alu_res} = {1'b0, acc_q} + {1'b0, bus.reg_rdata} + {8'h00, c_q};
      OP_SBC: {alu_c, alu_res} = {1'b0, acc_q} - {1'b0, bus.reg_rdata} - {8'h00, c_q};
      default: alu_res = acc_q;
    endcase
  end
`else
  always_comb begin
    alu_res = acc_q;
    case (opcode)
      OP_LDA: alu_res = bus.reg_rdata;
      OP_ADD: alu_res = acc_q + bus.reg_rdata;
      OP_SUB: alu_res = acc_q - bus.reg_rdata;
      OP_AND: alu_res = acc_q & bus.reg_rdata;
      OP_OR:  alu_res = acc_q | bus.reg_rdata;
      OP_XOR: alu_res = acc_q ^ bus.reg_rdata;
      default: alu_res = acc_q;
    endcase
  end
`endif

  // Strobes are registered with the state: each one is set on the edge
  // that enters the state it belongs to and cleared on the edge that
  // leaves it. Reset lands in FETCH, so the request is already up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= 8'h00;
      acc_q       <= 8'h00;
      z_q         <= 1'b1;
      imem_req_q  <= 1'b1;
      reg_read_q  <= 1'b0;
      reg_write_q <= 1'b0;
      halted_q    <= 1'b0;
`ifdef CPU_CTRL_CARRY_EN
      c_q         <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (bus.imem_ack) begin
            ir_q       <= bus.imem_data;
            pc_q       <= pc_q + 8'd1;
            imem_req_q <= 1'b0;
            state_q    <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              reg_read_q <= 1'b1;
              state_q    <= ST_READ;
            end
`ifdef CPU_CTRL_CARRY_EN
            OP_ADC, OP_SBC: begin
              reg_read_q <= 1'b1;
              state_q    <= ST_READ;
            end
`endif
            OP_STA: begin
              reg_write_q <= 1'b1;
              state_q     <= ST_WRITE;
            end
            OP_NOT: begin
              acc_q      <= ~acc_q;
              z_q        <= (acc_q == 8'hFF);
              imem_req_q <= 1'b1;
              state_q    <= ST_FETCH;
            end
            OP_LDI, OP_JMP, OP_JZ: begin
              imem_req_q <= 1'b1;
              state_q    <= ST_IMM;
            end
            OP_HLT: begin
              halted_q <= 1'b1;
              state_q  <= ST_HALT;
            end
            default: begin
              // NOP and the unassigned opcodes
              imem_req_q <= 1'b1;
              state_q    <= ST_FETCH;
            end
          endcase
        end

        ST_READ: begin
          acc_q      <= alu_res;
          z_q        <= (alu_res == 8'h00);
`ifdef CPU_CTRL_CARRY_EN
          c_q        <= alu_c;
`endif
          reg_read_q <= 1'b0;
          imem_req_q <= 1'b1;
          state_q    <= ST_FETCH;
        end

        ST_WRITE: begin
          reg_write_q <= 1'b0;
          imem_req_q  <= 1'b1;
          state_q     <= ST_FETCH;
        end

        ST_IMM: begin
          // Request stays high: the next state is FETCH.
          if (bus.imem_ack) begin
            case (opcode)
              OP_LDI: begin
                acc_q <= bus.imem_data;
                z_q   <= (bus.imem_data == 8'h00);
                pc_q  <= pc_q + 8'd1;
              end
              OP_JMP: pc_q <= bus.imem_data;
              OP_JZ:  pc_q <= z_q ? bus.imem_data : pc_q + 8'd1;
              default: pc_q <= pc_q + 8'd1;
            endcase
            state_q <= ST_FETCH;
          end
        end

        ST_HALT: begin
          // Only reset leaves HALT.
          state_q <= ST_HALT;
        end

        default: begin
          imem_req_q  <= 1'b1;
          reg_read_q  <= 1'b0;
          reg_write_q <= 1'b0;
          halted_q    <= 1'b0;
          state_q     <= ST_FETCH;
        end
      endcase
    end
  end

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = pc_q;
  assign bus.reg_write = reg_write_q;
  assign bus.reg_read  = reg_read_q;
  assign bus.reg_addr  = {4'h0, ir_q[3:0]};
  assign bus.reg_wdata = acc_q;

  assign acc    = acc_q;
  assign zero   = z_q;
  assign halted = halted_q;
`ifdef CPU_CTRL_CARRY_EN
  assign carry  = c_q;
`endif

endmodule

// File: doc/cpu_ctrl_seq.md
Name: cpu_ctrl_seq

Overview:
Fetch/decode/execute sequencer for the 8-bit CPU; sits directly upstream of the 16x8 general register file.
- Fetches 8-bit instructions from instruction memory over a req/ack handshake.
- Holds PC, IR, accumulator (ACC) and Z flag.
- Drives the register file's write/read/addr/data inputs and consumes its read data.
- Instruction format: IR[7:4] = opcode, IR[3:0] = register index.

Parameters:
RESET_PC, 8'h00, PC value loaded on reset.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
imem_req  out  1  instruction-memory request, held high until ack
imem_addr  out  8  fetch address (= PC while imem_req is high)
imem_ack  in  1  data valid this cycle; sampled only while imem_req is high
imem_data  in  8  instruction/operand byte, valid with imem_ack
reg_write  out  1  register-file write strobe, one cycle
reg_read  out  1  register-file read enable
reg_addr  out  8  register-file address = {4'h0, IR[3:0]}
reg_wdata  out  8  write data (= ACC)
reg_rdata  in  8  register-file read data, combinational from reg_addr when reg_read=1
acc  out  8  accumulator value
zero  out  1  Z flag, 1 when the last ACC write was 8'h00
halted  out  1  high in HALT state

Behaviour:
- Reset (async, any state): state=FETCH, PC=RESET_PC, IR=0, ACC=0, Z=1. All strobe outputs are 0; reg_addr=0, reg_wdata=0, imem_addr=RESET_PC.
- Outputs are decoded from state/IR only (Moore); no combinational path from inputs to outputs.
- FETCH: imem_req=1, imem_addr=PC.
  - On ack: IR<=imem_data, PC<=PC+1, go to DECODE.
  - No ack: stay in FETCH (unbounded wait).
- DECODE (1 cycle), by opcode:
  - 0 NOP: go to FETCH.
  - 1 LDA, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR: go to READ.
  - 2 STA: go to WRITE.
  - 8 NOT: ACC<=~ACC, go to FETCH.
  - 9 LDI, A JMP, B JZ: go to IMM.
  - F HLT: go to HALT.
  - C, D, E: treated as NOP (see optional feature for C/D).
- READ (1 cycle): reg_read=1. ACC<=f(ACC, reg_rdata), go to FETCH.
  - LDA: ACC<=rdata
  - ADD: ACC<=ACC+rdata, mod 256, carry discarded
  - SUB: ACC<=ACC-rdata, mod 256
  - AND / OR / XOR: bitwise
- WRITE (1 cycle): reg_write=1, reg_wdata=ACC. Go to FETCH; ACC and Z unchanged.
- IMM: imem_req=1, imem_addr=PC. On ack:
  - LDI: ACC<=imem_data, PC<=PC+1.
  - JMP: PC<=imem_data.
  - JZ: PC<=imem_data if Z=1, else PC<=PC+1.
  - Then go to FETCH.
- HALT: all strobes 0, halted=1. Only reset exits HALT.
- Z is updated on every ACC write (LDA, ALU ops, NOT, LDI) and is unchanged otherwise.
- PC wraps 8'hFF -> 8'h00. An operand fetch at 8'hFF reads the operand from 8'hFF and then PC becomes 8'h00.
- reg_read and reg_write are never high in the same cycle. imem_req is never high together with either of them.
- Latency with zero-wait ack:
  - NOP / NOT: 2 cycles
  - LDA / ALU ops / STA: 3 cycles
  - LDI / JMP / JZ: 3 cycles
- Reset mid-operation aborts any pending request or write. reg_write falls asynchronously with rst.

Optional Feature:
Macro CPU_CTRL_CARRY_EN.
- Defined:
  - Adds carry flag C (reset 0) and output port carry (1 bit).
  - ADD sets C=carry-out; SUB sets C=borrow.
  - Opcode C = ADC r: ACC<=ACC+rdata+C, C=carry-out.
  - Opcode D = SBC r: ACC<=ACC-rdata-C, C=borrow.
  - Both ADC and SBC go through the READ state.
- Not defined: no C flag and no carry port; opcodes C/D behave as NOP.

Test Plan:
- Reset, then ack on every fetch -> imem_addr=00 in cycle 1; ACC=0, Z=1, halted=0.
- Program LDI 8'h05 (90 05), STA r3 (23) -> reg_write high exactly 1 cycle with reg_addr=03, reg_wdata=05; next FETCH at PC=03.
- reg_rdata=8'hFB with ACC=05, ADD r1 -> ACC=00, Z=1; with CPU_CTRL_CARRY_EN, carry=1.
- JZ with Z=1 and operand 40 -> next imem_addr=40; JZ with Z=0 -> next imem_addr=PC+2 of the JZ.
- Hold imem_ack low 5 cycles during FETCH -> imem_req stays high, PC/IR unchanged; proceeds on ack.
- HLT (F0) -> halted=1, no further imem_req; assert rst for 1 cycle -> FETCH at RESET_PC.
